cutoff_envelope: RTL and testbench

Per-sample ADSR envelope generator that produces the 24-bit filter cutoff for the 2-pole lowpass stage directly downstream. Each sample, the voice controller pulses the start handshake. The block then does two things: it advances the envelope state machine by one step, and it scales the envelope through the shared multiplier. It returns the cutoff with a finish pulse, and the controller forwards that cutoff to the lowpass stage's `cutoff` input.

---
 rtl/cutoff_envelope.sv | 152 +++++++++++++++
 tb/tb_cutoff_envelope.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cutoff_envelope.sv
// Per-sample ADSR envelope that scales env_depth through the shared multiplier
// and adds base_cutoff to drive the downstream lowpass cutoff.
module cutoff_envelope (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        finish,
    input  logic        gate,
    input  logic [31:0] attack_rate,
    input  logic [31:0] decay_rate,
    input  logic [31:0] sustain_level,
    input  logic [31:0] release_rate,
    input  logic [23:0] base_cutoff,
    input  logic [23:0] env_depth,
    input  logic [63:0] mult_p,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic [23:0] cutoff
);

    localparam int unsigned LEVEL_W  = 32;
    localparam int unsigned CUTOFF_W = 24;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        PH_OFF     = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_t;

    state_t                state, state_next;
    phase_t                phase, phase_next, eff_phase;
    logic [LEVEL_W-1:0]    level, level_next;
    logic                  gate_q, gate_next;
    logic [CUTOFF_W-1:0]   cutoff_next;
    logic                  finish_next;
    logic [31:0]           mult_a_next, mult_b_next;
    logic [LEVEL_W:0]      att_sum, dec_diff;
    logic [CUTOFF_W:0]     cap_sum;
    logic                  unused_mult;

    // Only the (depth*level)>>32 window of the product is consumed.
    assign unused_mult = ^{mult_p[63:56], mult_p[31:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            phase  <= PH_OFF;
            level  <= '0;
            gate_q <= 1'b0;
            cutoff <= '0;
            finish <= 1'b0;
            mult_a <= '0;
            mult_b <= '0;
        end else begin
            state  <= state_next;
            phase  <= phase_next;
            level  <= level_next;
            gate_q <= gate_next;
            cutoff <= cutoff_next;
            finish <= finish_next;
            mult_a <= mult_a_next;
            mult_b <= mult_b_next;
        end
    end

    always_comb begin
        state_next  = state;
        phase_next  = phase;
        level_next  = level;
        gate_next   = gate_q;
        cutoff_next = cutoff;
        finish_next = 1'b0;
        mult_a_next = '0;
        mult_b_next = '0;
        eff_phase   = phase;
        att_sum     = {1'b0, level} + {1'b0, attack_rate};
        dec_diff    = {1'b0, level} - {1'b0, decay_rate};
        cap_sum     = {1'b0, base_cutoff} + {1'b0, mult_p[55:32]};

        case (state)
            S_IDLE: begin
                if (start) begin
                    gate_next  = gate;
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                // Gate edges redirect the phase before this sample's level step.
                if (gate_q && (phase == PH_OFF || phase == PH_RELEASE))
                    eff_phase = PH_ATTACK;
                else if (!gate_q && (phase == PH_ATTACK || phase == PH_DECAY ||
                                     phase == PH_SUSTAIN))
                    eff_phase = PH_RELEASE;
                phase_next = eff_phase;

                case (eff_phase)
                    PH_ATTACK: begin
                        if (att_sum[LEVEL_W] || (att_sum[LEVEL_W-1:0] == '1)) begin
                            level_next = '1;
                            phase_next = PH_DECAY;
                        end else begin
                            level_next = att_sum[LEVEL_W-1:0];
                        end
                    end
                    PH_DECAY: begin
                        if (dec_diff[LEVEL_W] || (dec_diff[LEVEL_W-1:0] <= sustain_level)) begin
                            level_next = sustain_level;
                            phase_next = PH_SUSTAIN;
                        end else begin
                            level_next = dec_diff[LEVEL_W-1:0];
                        end
                    end
                    PH_SUSTAIN: level_next = sustain_level;
                    PH_RELEASE: begin
                        if (release_rate >= level) begin
                            level_next = '0;
                            phase_next = PH_OFF;
                        end else begin
                            level_next = level - release_rate;
                        end
                    end
                    default: level_next = level;
                endcase

                mult_a_next = {8'b0, env_depth};
                mult_b_next = level_next;
                state_next  = S_ISSUE;
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  state_next = S_CAP;
            S_CAP: begin
                cutoff_next = cap_sum[CUTOFF_W] ? '1 : cap_sum[CUTOFF_W-1:0];
                finish_next = 1'b1;
                state_next  = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cutoff_envelope.sv
// Directed table-driven bench for cutoff_envelope with a two-stage multiplier model.
module tb_cutoff_envelope;

    logic        clk;
    logic        rst;
    logic        start;
    logic        finish;
    logic        gate;
    logic [31:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic [23:0] base_cutoff, env_depth;
    logic [63:0] mult_p;
    logic [31:0] mult_a, mult_b;
    logic [23:0] cutoff;
    logic [63:0] p1, p2;

    int n_cmp;
    int n_err;

    localparam logic [2:0] OFF = 3'd0, ATT = 3'd1, DEC = 3'd2, SUS = 3'd3, REL = 3'd4;

    typedef struct {
        logic        gate;
        logic [31:0] att;
        logic [31:0] dec;
        logic [31:0] sus;
        logic [31:0] rel;
        logic [23:0] base;
        logic [23:0] depth;
        logic [23:0] exp_cutoff;
        logic [31:0] exp_level;
        logic [2:0]  exp_phase;
    } vec_t;

    vec_t vecs[16];

    cutoff_envelope dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .finish        (finish),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .base_cutoff   (base_cutoff),
        .env_depth     (env_depth),
        .mult_p        (mult_p),
        .mult_a        (mult_a),
        .mult_b        (mult_b),
        .cutoff        (cutoff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: product visible two cycles after the operands.
    always @(posedge clk) begin
        p1 <= 64'(mult_a) * 64'(mult_b);
        p2 <= p1;
    end
    assign mult_p = p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_sample(input vec_t v, input string tag);
        int cnt;
        cnt = 0;
        @(negedge clk);
        gate          = v.gate;
        attack_rate   = v.att;
        decay_rate    = v.dec;
        sustain_level = v.sus;
        release_rate  = v.rel;
        base_cutoff   = v.base;
        env_depth     = v.depth;
        start         = 1'b1;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!finish && cnt < 20);
        start = 1'b0;
        check({tag, "_latency"}, 32'(cnt), 32'd5);
        check({tag, "_cutoff"}, 32'(cutoff), 32'(v.exp_cutoff));
        check({tag, "_level"}, dut.level, v.exp_level);
        check({tag, "_phase"}, 32'(dut.phase), 32'(v.exp_phase));
        @(posedge clk);
        #1;
        check({tag, "_finish_drop"}, 32'(finish), 32'd0);
    endtask

    initial begin
        bit saw_finish;
        vec_t v;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        start = 1'b0;
        gate = 1'b0;
        attack_rate = '0;
        decay_rate = '0;
        sustain_level = '0;
        release_rate = '0;
        base_cutoff = '0;
        env_depth = '0;

        //           gate  attack        decay         sustain       release       base        depth       cutoff      level         phase
        vecs[0]  = '{1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        24'd51200,  24'd256000, 24'd51200,  32'h0,        OFF};
        vecs[1]  = '{1'b1, 32'h40000000, 32'h0,        32'h0,        32'h0,        24'h0,      24'h010000, 24'h004000, 32'h40000000, ATT};
        vecs[2]  = '{1'b1, 32'h40000000, 32'h0,        32'h0,        32'h0,        24'h0,      24'h010000, 24'h008000, 32'h80000000, ATT};
        vecs[3]  = '{1'b1, 32'h40000000, 32'h0,        32'h0,        32'h0,        24'h0,      24'h010000, 24'h00C000, 32'hC0000000, ATT};
        vecs[4]  = '{1'b1, 32'h40000000, 32'h0,        32'h0,        32'h0,        24'h0,      24'h010000, 24'h00FFFF, 32'hFFFFFFFF, DEC};
        vecs[5]  = '{1'b1, 32'h0,        32'h40000000, 32'h80000000, 32'h0,        24'h0,      24'h010000, 24'h00BFFF, 32'hBFFFFFFF, DEC};
        vecs[6]  = '{1'b1, 32'h0,        32'h40000000, 32'h80000000, 32'h0,        24'h0,      24'h010000, 24'h008000, 32'h80000000, SUS};
        vecs[7]  = '{1'b1, 32'h0,        32'h40000000, 32'h20000000, 32'h0,        24'h0,      24'h010000, 24'h002000, 32'h20000000, SUS};
        vecs[8]  = '{1'b0, 32'h0,        32'h0,        32'h20000000, 32'h10000000, 24'h0,      24'h010000, 24'h001000, 32'h10000000, REL};
        vecs[9]  = '{1'b0, 32'h0,        32'h0,        32'h20000000, 32'h10000000, 24'h0,      24'h010000, 24'h000000, 32'h0,        OFF};
        vecs[10] = '{1'b0, 32'h0,        32'h0,        32'h0,        32'h10000000, 24'h123456, 24'h010000, 24'h123456, 32'h0,        OFF};
        vecs[11] = '{1'b1, 32'h20000000, 32'h0,        32'h0,        32'h0,        24'h0,      24'h010000, 24'h002000, 32'h20000000, ATT};
        vecs[12] = '{1'b0, 32'h0,        32'h0,        32'h0,        32'h10000000, 24'h0,      24'h010000, 24'h001000, 32'h10000000, REL};
        vecs[13] = '{1'b1, 32'h10000000, 32'h0,        32'h0,        32'h10000000, 24'h0,      24'h010000, 24'h002000, 32'h20000000, ATT};
        vecs[14] = '{1'b1, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        24'hFF0000, 24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFFFF, DEC};
        vecs[15] = '{1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        24'h0,      24'h010000, 24'h00FFFF, 32'hFFFFFFFF, DEC};

        repeat (3) @(posedge clk);
        #1;
        check("reset_cutoff", 32'(cutoff), 32'd0);
        check("reset_finish", 32'(finish), 32'd0);
        check("reset_level", dut.level, 32'd0);
        check("reset_phase", 32'(dut.phase), 32'(OFF));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++)
            run_sample(vecs[i], $sformatf("vec%0d", i));

        // Reset dropped while the product is in flight.
        @(negedge clk);
        gate = 1'b0;
        base_cutoff = 24'h000100;
        env_depth = 24'h010000;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        #1;
        check("midrst_cutoff", 32'(cutoff), 32'd0);
        check("midrst_finish", 32'(finish), 32'd0);
        saw_finish = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (finish) saw_finish = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (finish) saw_finish = 1'b1;
        end
        check("midrst_no_finish", 32'(saw_finish), 32'd0);
        check("midrst_level", dut.level, 32'd0);
        check("midrst_phase", 32'(dut.phase), 32'(OFF));

        v = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 24'h000100, 24'h010000, 24'h000100, 32'h0, OFF};
        run_sample(v, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
